// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: forwarding select encodings, mult/div occupancy
// states and the default register-address width.
package cpu_pipe_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned FWD_W      = 2;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'd0;
  localparam logic [FWD_W-1:0] FWD_EX  = 2'd1;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'd2;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // Youngest producer wins: EX over MEM over WB.
  function automatic logic [FWD_W-1:0] fwd_pick(input logic ex_hit,
                                                input logic mem_hit,
                                                input logic wb_hit);
    logic [FWD_W-1:0] sel;
    sel = FWD_RF;
    if (ex_hit)       sel = FWD_EX;
    else if (mem_hit) sel = FWD_MEM;
    else if (wb_hit)  sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/md_occupancy_fsm.sv
// Mult/div unit occupancy tracker: an accepted start keeps the unit busy for
// MD_LAT-1 cycles followed by a single DONE cycle.
module md_occupancy_fsm
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned MD_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam int unsigned CW = (MD_LAT > 2) ? $clog2(MD_LAT - 1) : 1;

  md_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  // Countdown loads MD_LAT-2 so BUSY spans MD_LAT-1 cycles including count 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= BUSY;
            cnt_q   <= CW'(MD_LAT - 2);
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (start) begin
            state_q <= BUSY;
            cnt_q   <= CW'(MD_LAT - 2);
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline. Define
// HAZARD_FWD_EN for bypassing; otherwise every producer match stalls.
module hazard_ctrl_unit
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned MD_LAT = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_md_start,
  input  logic              id_reads_hilo,
  input  logic              ex_wen,
  input  logic              mem_wen,
  input  logic              wb_wen,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic              ex_is_load,
  output logic              stall_pc,
  output logic              stall_id,
  output logic              flush_ex,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  function automatic logic stage_hit(input logic              uses,
                                     input logic              wen,
                                     input logic [ADDR_W-1:0] waddr,
                                     input logic [ADDR_W-1:0] raddr);
    return uses && wen && (waddr != '0) && (waddr == raddr);
  endfunction

  logic ex_rs_hit, mem_rs_hit, wb_rs_hit;
  logic ex_rt_hit, mem_rt_hit, wb_rt_hit;
  logic raw_haz, hilo_haz, stall_c, md_start_acc;
  logic [CNT_W-1:0] stall_cnt_q;

  always_comb begin
    ex_rs_hit  = stage_hit(id_uses_rs, ex_wen,  ex_waddr,  id_rs);
    mem_rs_hit = stage_hit(id_uses_rs, mem_wen, mem_waddr, id_rs);
    wb_rs_hit  = stage_hit(id_uses_rs, wb_wen,  wb_waddr,  id_rs);
    ex_rt_hit  = stage_hit(id_uses_rt, ex_wen,  ex_waddr,  id_rt);
    mem_rt_hit = stage_hit(id_uses_rt, mem_wen, mem_waddr, id_rt);
    wb_rt_hit  = stage_hit(id_uses_rt, wb_wen,  wb_waddr,  id_rt);
  end

`ifdef HAZARD_FWD_EN
  // Only a load still in EX cannot be bypassed.
  assign raw_haz    = ex_is_load && (ex_rs_hit || ex_rt_hit);
  assign fwd_rs_sel = fwd_pick(ex_rs_hit, mem_rs_hit, wb_rs_hit);
  assign fwd_rt_sel = fwd_pick(ex_rt_hit, mem_rt_hit, wb_rt_hit);
`else
  logic unused_load_flag;
  assign unused_load_flag = ex_is_load;
  assign raw_haz    = ex_rs_hit || mem_rs_hit || wb_rs_hit ||
                      ex_rt_hit || mem_rt_hit || wb_rt_hit;
  assign fwd_rs_sel = FWD_RF;
  assign fwd_rt_sel = FWD_RF;
`endif

  // A second mult/div or any HI/LO access waits out the busy unit.
  assign hilo_haz     = md_busy && (id_reads_hilo || id_md_start);
  assign stall_c      = raw_haz || hilo_haz;
  assign md_start_acc = id_md_start && !stall_c;

  assign stall_id = stall_c;
  assign stall_pc = stall_c;
  assign flush_ex = stall_c;

  md_occupancy_fsm #(
    .MD_LAT(MD_LAT)
  ) u_md_fsm (
    .clk  (clk),
    .rst_n(rst_n),
    .start(md_start_acc),
    .busy (md_busy)
  );

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed scenarios plus random traffic
// against a cycle-indexed reference model; honours HAZARD_FWD_EN.
module tb_hazard_ctrl_unit;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned MD_LAT = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] id_rs, id_rt, ex_waddr, mem_waddr, wb_waddr;
  logic              id_uses_rs, id_uses_rt, id_md_start, id_reads_hilo;
  logic              ex_wen, mem_wen, wb_wen, ex_is_load;
  logic              stall_pc, stall_id, flush_ex, md_busy;
  logic [1:0]        fwd_rs_sel, fwd_rt_sel;
  logic [CNT_W-1:0]  stall_cnt;

  typedef struct packed {
    logic              rst_n;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              urs;
    logic              urt;
    logic              md;
    logic              hilo;
    logic              exw;
    logic [ADDR_W-1:0] exa;
    logic              memw;
    logic [ADDR_W-1:0] mema;
    logic              wbw;
    logic [ADDR_W-1:0] wba;
    logic              ld;
  } stim_t;

  typedef struct packed {
    logic             stall;
    logic [1:0]       rs;
    logic [1:0]       rt;
    logic             busy;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: cycle index, cycle of last accepted mult/div, stalls.
  int cyc       = 0;
  int last_acc  = -1000;
  int stall_tot = 0;

  hazard_ctrl_unit #(
    .ADDR_W(ADDR_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start), .id_reads_hilo(id_reads_hilo),
    .ex_wen(ex_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
    .ex_waddr(ex_waddr), .mem_waddr(mem_waddr), .wb_waddr(wb_waddr),
    .ex_is_load(ex_is_load),
    .stall_pc(stall_pc), .stall_id(stall_id), .flush_ex(flush_ex),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    case ($urandom % 4)
      0:       return '0;
      1:       return ADDR_W'(8);
      2:       return ADDR_W'(9);
      default: return ADDR_W'($urandom % 32);
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s       = idle_stim();
    s.rst_n = ($urandom % 64) != 0;
    s.rs    = rand_addr();
    s.rt    = rand_addr();
    s.urs   = ($urandom % 4) != 0;
    s.urt   = ($urandom % 2) != 0;
    s.md    = ($urandom % 6) == 0;
    s.hilo  = ($urandom % 6) == 0;
    s.exw   = ($urandom % 2) != 0;
    s.exa   = rand_addr();
    s.memw  = ($urandom % 2) != 0;
    s.mema  = rand_addr();
    s.wbw   = ($urandom % 2) != 0;
    s.wba   = rand_addr();
    s.ld    = ($urandom % 3) == 0;
    return s;
  endfunction

  function automatic bit hit(input logic uses, input logic wen,
                             input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] ra);
    return uses && wen && (wa != 0) && (wa == ra);
  endfunction

  // Selects the youngest matching stage; 0 when none matches.
  function automatic logic [1:0] youngest(input bit h_ex, input bit h_mem, input bit h_wb);
    bit h[3];
    h[0] = h_ex; h[1] = h_mem; h[2] = h_wb;
    for (int i = 0; i < 3; i++) if (h[i]) return 2'(i + 1);
    return 2'd0;
  endfunction

  // Applies one cycle of stimulus, predicts this cycle's outputs, advances model.
  task automatic drive(input stim_t s, input bit chk);
    bit   hrs[3], hrt[3];
    bit   busy, any, stall;
    exp_t e;
    rst_n = s.rst_n; id_rs = s.rs; id_rt = s.rt;
    id_uses_rs = s.urs; id_uses_rt = s.urt;
    id_md_start = s.md; id_reads_hilo = s.hilo;
    ex_wen = s.exw; ex_waddr = s.exa; mem_wen = s.memw; mem_waddr = s.mema;
    wb_wen = s.wbw; wb_waddr = s.wba; ex_is_load = s.ld;

    busy = (cyc > last_acc) && (cyc < last_acc + int'(MD_LAT));
    hrs[0] = hit(s.urs, s.exw,  s.exa,  s.rs);
    hrs[1] = hit(s.urs, s.memw, s.mema, s.rs);
    hrs[2] = hit(s.urs, s.wbw,  s.wba,  s.rs);
    hrt[0] = hit(s.urt, s.exw,  s.exa,  s.rt);
    hrt[1] = hit(s.urt, s.memw, s.mema, s.rt);
    hrt[2] = hit(s.urt, s.wbw,  s.wba,  s.rt);
    any = hrs[0] || hrs[1] || hrs[2] || hrt[0] || hrt[1] || hrt[2];
`ifdef HAZARD_FWD_EN
    stall = (s.ld && (hrs[0] || hrt[0])) || (busy && (s.hilo || s.md));
    e.rs  = youngest(hrs[0], hrs[1], hrs[2]);
    e.rt  = youngest(hrt[0], hrt[1], hrt[2]);
`else
    stall = any || (busy && (s.hilo || s.md));
    e.rs  = 2'd0;
    e.rt  = 2'd0;
`endif
    e.stall = stall;
    e.busy  = busy;
    e.cnt   = CNT_W'((stall_tot > CNT_MAX) ? CNT_MAX : stall_tot);
    if (chk) exp_q.push_back(e);

    if (!s.rst_n) begin
      last_acc  = -1000;
      stall_tot = 0;
    end else begin
      if (stall) stall_tot++;
      if (s.md && !stall) last_acc = cyc;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest prediction, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stall_id",   32'(stall_id),   32'(e.stall));
      check("stall_pc",   32'(stall_pc),   32'(e.stall));
      check("flush_ex",   32'(flush_ex),   32'(e.stall));
      check("fwd_rs_sel", 32'(fwd_rs_sel), 32'(e.rs));
      check("fwd_rt_sel", 32'(fwd_rt_sel), 32'(e.rt));
      check("md_busy",    32'(md_busy),    32'(e.busy));
      check("stall_cnt",  32'(stall_cnt),  32'(e.cnt));
    end
  end

  initial begin
    stim_t s;
    s = idle_stim(); s.rst_n = 1'b0;
    drive(s, 1'b0);
    drive(s, 1'b1);

    // Forwarding priority on rs=$8.
    s = idle_stim(); s.rs = 5'd8; s.urs = 1'b1; s.exw = 1'b1; s.exa = 5'd8;
    drive(s, 1'b1);
    s.memw = 1'b1; s.mema = 5'd8;
    drive(s, 1'b1);
    s.exw = 1'b0;
    drive(s, 1'b1);
    s.memw = 1'b0; s.wbw = 1'b1; s.wba = 5'd8;
    drive(s, 1'b1);

    // Load-use on rt=$9, then the load has moved to MEM.
    s = idle_stim(); s.rt = 5'd9; s.urt = 1'b1; s.ld = 1'b1; s.exw = 1'b1; s.exa = 5'd9;
    drive(s, 1'b1);
    s.ld = 1'b0; s.exw = 1'b0; s.memw = 1'b1; s.mema = 5'd9;
    drive(s, 1'b1);

    // Register 0 never hazards.
    s = idle_stim(); s.urs = 1'b1; s.urt = 1'b1; s.ld = 1'b1;
    s.exw = 1'b1; s.memw = 1'b1; s.wbw = 1'b1;
    drive(s, 1'b1);

    // Mult/div occupancy, mfhi held until DONE, then reset while busy.
    s = idle_stim(); s.md = 1'b1;
    drive(s, 1'b1);
    s = idle_stim(); s.hilo = 1'b1;
    repeat (MD_LAT) drive(s, 1'b1);
    s = idle_stim();
    drive(s, 1'b1);
    s.md = 1'b1;
    drive(s, 1'b1);
    s = idle_stim();
    drive(s, 1'b1);
    s.rst_n = 1'b0;
    drive(s, 1'b1);
    s.rst_n = 1'b1;
    drive(s, 1'b1);

    // Saturate the stall counter with a held load-use hazard.
    s = idle_stim(); s.rt = 5'd9; s.urt = 1'b1; s.ld = 1'b1; s.exw = 1'b1; s.exa = 5'd9;
    repeat ((1 << CNT_W) + 5) drive(s, 1'b1);
    s = idle_stim();
    drive(s, 1'b1);

    s = idle_stim(); s.rst_n = 1'b0;
    drive(s, 1'b1);
    repeat (2000) drive(rand_stim(), 1'b1);
    s = idle_stim();
    drive(s, 1'b0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
